// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bus: ID-stage instruction fields and hazard inputs going in,
// per-stage control bundles coming out. The master drives the ID side, the
// slave (pipe_ctrl) produces the stage controls.
interface pipe_ctrl_if #(
    parameter int RW = 5
);
    logic [10:0]   op;
    logic          id_valid;
    logic [RW-1:0] id_rn;
    logic [RW-1:0] id_rm;
    logic [RW-1:0] id_rd;
    logic          stall;
    logic          flush;

    logic          ex_reg2loc;
    logic          ex_alusrc;
    logic [1:0]    ex_aluop;
    logic [RW-1:0] ex_rd;
    logic          mem_memread;
    logic          mem_memwrite;
    logic          mem_branch;
    logic          mem_zinv;
    logic [RW-1:0] mem_rd;
    logic          wb_regwrite;
    logic          wb_memtoreg;
    logic [RW-1:0] wb_rd;
    logic          stall_req;

    modport master (
        output op, id_valid, id_rn, id_rm, id_rd, stall, flush,
        input  ex_reg2loc, ex_alusrc, ex_aluop, ex_rd,
        input  mem_memread, mem_memwrite, mem_branch, mem_zinv, mem_rd,
        input  wb_regwrite, wb_memtoreg, wb_rd, stall_req
    );

    modport slave (
        input  op, id_valid, id_rn, id_rm, id_rd, stall, flush,
        output ex_reg2loc, ex_alusrc, ex_aluop, ex_rd,
        output mem_memread, mem_memwrite, mem_branch, mem_zinv, mem_rd,
        output wb_regwrite, wb_memtoreg, wb_rd, stall_req
    );
endinterface

// File: rtl/pipe_ctrl.sv
// LEGv8 pipeline control: decodes the ID opcode and carries the control
// bundle through ID/EX, EX/MEM and MEM/WB, with bubble insertion on stall and
// squash of the two youngest stages on a taken-branch flush.
// Optional feature: define PIPE_CTRL_HAZARD_DETECT_EN to enable the internal
// load-use hazard detector driving stall_req; otherwise stall_req is 0.
module pipe_ctrl #(
    parameter int RW      = 5,
    parameter bit EXT_OPS = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    pipe_ctrl_if.slave bus
);

    // Field order mirrors the decode table so each entry reads as one literal.
    typedef struct packed {
        logic       reg2loc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       alusrc;
        logic [1:0] aluop;
        logic       zinv;
    } ctrl_t;

    typedef struct packed {
        logic          reg2loc;
        logic          alusrc;
        logic [1:0]    aluop;
        logic          memread;
        logic          memwrite;
        logic          branch;
        logic          zinv;
        logic          regwrite;
        logic          memtoreg;
        logic [RW-1:0] rd;
    } id_ex_t;

    typedef struct packed {
        logic          memread;
        logic          memwrite;
        logic          branch;
        logic          zinv;
        logic          regwrite;
        logic          memtoreg;
        logic [RW-1:0] rd;
    } ex_mem_t;

    typedef struct packed {
        logic          regwrite;
        logic          memtoreg;
        logic [RW-1:0] rd;
    } mem_wb_t;

    ctrl_t   dec;
    id_ex_t  id_ex_d;
    id_ex_t  id_ex;
    ex_mem_t ex_mem;
    mem_wb_t mem_wb;
    logic    stall_req;
    logic    bubble;

    // Opcode decode; anything unrecognised or an invalid slot yields all-zero controls.
    always_comb begin
        // NOTE: default first so every path assigns dec and no latch is inferred.
        dec = '0;
        if (bus.id_valid) begin
            casez (bus.op)
                11'b11010110000,
                11'b1?001011000,
                11'b10?01010000: dec = 10'b0_0_1_0_0_0_0_10_0;
                11'b10110100???: dec = 10'b1_0_0_0_0_1_0_01_0;
                11'b11111000010: dec = 10'b0_1_1_1_0_0_1_00_0;
                11'b11111000000: dec = 10'b1_0_0_0_1_0_1_00_0;
                11'b1?0100010??: if (EXT_OPS) dec = 10'b0_0_1_0_0_0_1_10_0;
                11'b10110101???: if (EXT_OPS) dec = 10'b1_0_0_0_0_1_0_01_1;
                default:         dec = '0;
            endcase
        end
    end

`ifdef PIPE_CTRL_HAZARD_DETECT_EN
    // Load-use hazard: the load in EX writes a register the ID instruction reads.
    // XZR (all-ones) is never a real dependency.
    assign stall_req = id_ex.memread
                     & (id_ex.rd != '1)
                     & ((id_ex.rd == bus.id_rn) | (id_ex.rd == bus.id_rm))
                     & bus.id_valid;
`else
    assign stall_req = 1'b0;
    // Source-register fields only matter to the hazard detector.
    logic unused_src_regs;
    assign unused_src_regs = ^{bus.id_rn, bus.id_rm};
`endif

    assign bubble = bus.stall | stall_req;

    // ID/EX next value: the decoded bundle, or a zero bubble on stall or flush.
    always_comb begin
        id_ex_d = '0;
        if (!(bus.flush || bubble)) begin
            id_ex_d.reg2loc  = dec.reg2loc;
            id_ex_d.alusrc   = dec.alusrc;
            id_ex_d.aluop    = dec.aluop;
            id_ex_d.memread  = dec.memread;
            id_ex_d.memwrite = dec.memwrite;
            id_ex_d.branch   = dec.branch;
            id_ex_d.zinv     = dec.zinv;
            id_ex_d.regwrite = dec.regwrite;
            id_ex_d.memtoreg = dec.memtoreg;
            id_ex_d.rd       = bus.id_rd;
        end
    end

    // ID/EX register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking so all three stage registers sample pre-edge values.
        if (!reset) id_ex <= '0;
        else        id_ex <= id_ex_d;
    end

    // EX/MEM register: drops EX-only fields; squashed by flush, not by stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_mem <= '0;
        end else if (bus.flush) begin
            ex_mem <= '0;
        end else begin
            ex_mem.memread  <= id_ex.memread;
            ex_mem.memwrite <= id_ex.memwrite;
            ex_mem.branch   <= id_ex.branch;
            ex_mem.zinv     <= id_ex.zinv;
            ex_mem.regwrite <= id_ex.regwrite;
            ex_mem.memtoreg <= id_ex.memtoreg;
            ex_mem.rd       <= id_ex.rd;
        end
    end

    // MEM/WB register: always advances so older instructions still write back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_wb <= '0;
        end else begin
            mem_wb.regwrite <= ex_mem.regwrite;
            mem_wb.memtoreg <= ex_mem.memtoreg;
            mem_wb.rd       <= ex_mem.rd;
        end
    end

    assign bus.ex_reg2loc   = id_ex.reg2loc;
    assign bus.ex_alusrc    = id_ex.alusrc;
    assign bus.ex_aluop     = id_ex.aluop;
    assign bus.ex_rd        = id_ex.rd;
    assign bus.mem_memread  = ex_mem.memread;
    assign bus.mem_memwrite = ex_mem.memwrite;
    assign bus.mem_branch   = ex_mem.branch;
    assign bus.mem_zinv     = ex_mem.zinv;
    assign bus.mem_rd       = ex_mem.rd;
    assign bus.wb_regwrite  = mem_wb.regwrite;
    assign bus.wb_memtoreg  = mem_wb.memtoreg;
    assign bus.wb_rd        = mem_wb.rd;
    assign bus.stall_req    = stall_req;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: two instances (extended ops on and off) driven
// with the same ID stimulus; stage outputs sampled 1 ns after each rising edge.
module tb_pipe_ctrl;
    localparam int RW = 5;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_CBNZ = 11'b10110101000;
    localparam logic [10:0] OP_ADDI = 11'b10010001000;
    localparam logic [10:0] OP_UNK  = 11'b00000000000;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.RW(RW)) bus1 ();
    pipe_ctrl_if #(.RW(RW)) bus0 ();

    pipe_ctrl #(.RW(RW), .EXT_OPS(1'b1)) dut  (.clk(clk), .reset(reset), .bus(bus1.slave));
    pipe_ctrl #(.RW(RW), .EXT_OPS(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {reg2loc, alusrc, aluop, rd}
    task automatic check_ex(input string tag, input logic [8:0] exp);
        check(tag, {bus1.ex_reg2loc, bus1.ex_alusrc, bus1.ex_aluop, bus1.ex_rd}, exp);
    endtask

    // {memread, memwrite, branch, zinv, rd}
    task automatic check_mem(input string tag, input logic [8:0] exp);
        check(tag, {bus1.mem_memread, bus1.mem_memwrite, bus1.mem_branch, bus1.mem_zinv,
                    bus1.mem_rd}, exp);
    endtask

    // {regwrite, memtoreg, rd}
    task automatic check_wb(input string tag, input logic [6:0] exp);
        check(tag, {bus1.wb_regwrite, bus1.wb_memtoreg, bus1.wb_rd}, exp);
    endtask

    task automatic drive(input logic [10:0] op, input logic valid, input logic [RW-1:0] rn,
                         input logic [RW-1:0] rm, input logic [RW-1:0] rd,
                         input logic stall, input logic flush);
        bus1.op = op; bus1.id_valid = valid; bus1.id_rn = rn; bus1.id_rm = rm;
        bus1.id_rd = rd; bus1.stall = stall; bus1.flush = flush;
        bus0.op = op; bus0.id_valid = valid; bus0.id_rn = rn; bus0.id_rm = rm;
        bus0.id_rd = rd; bus0.stall = stall; bus0.flush = flush;
    endtask

    task automatic idle();
        drive(OP_UNK, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        idle();
        #2;
        check_ex("rst_ex", '0);
        check_mem("rst_mem", '0);
        check_wb("rst_wb", '0);
        check("rst_stall_req", bus1.stall_req, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // LDUR rd=3 walks through EX, MEM, WB
        drive(OP_LDUR, 1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
        tick();
        check_ex("ldur_ex", {1'b0, 1'b1, 2'b00, 5'd3});
        idle();
        tick();
        check_mem("ldur_mem", {4'b1000, 5'd3});
        check_ex("ldur_ex_drained", '0);
        tick();
        check_wb("ldur_wb", {2'b11, 5'd3});

        // ADD followed by STUR
        drive(OP_ADD, 1'b1, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0);
        tick();
        check_ex("add_ex", {1'b0, 1'b0, 2'b10, 5'd7});
        drive(OP_STUR, 1'b1, 5'd1, 5'd2, 5'd9, 1'b0, 1'b0);
        tick();
        check_ex("stur_ex", {1'b1, 1'b1, 2'b00, 5'd9});
        check_mem("add_mem", {4'b0000, 5'd7});
        idle();
        tick();
        check_mem("stur_mem", {4'b0100, 5'd9});
        check_wb("add_wb", {2'b10, 5'd7});
        tick();
        check_wb("stur_wb", {2'b00, 5'd9});

        // Other R-format encodings
        drive(OP_ORR, 1'b1, 5'd3, 5'd4, 5'd1, 1'b0, 1'b0);
        tick();
        check_ex("orr_ex", {1'b0, 1'b0, 2'b10, 5'd1});
        drive(OP_SUB, 1'b1, 5'd3, 5'd4, 5'd2, 1'b0, 1'b0);
        tick();
        check_ex("sub_ex", {1'b0, 1'b0, 2'b10, 5'd2});
        idle();
        tick(); tick(); tick();

        // CBZ resolves in MEM, flush kills the two younger ops
        drive(OP_CBZ, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        check_ex("cbz_ex", {1'b1, 1'b0, 2'b01, 5'd0});
        drive(OP_ADD, 1'b1, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0);
        tick();
        check_mem("cbz_mem", {4'b0010, 5'd0});
        drive(OP_ADD, 1'b1, 5'd0, 5'd0, 5'd6, 1'b0, 1'b1);
        tick();
        check_ex("flush_ex", '0);
        check_mem("flush_mem", '0);
        check_wb("cbz_wb", '0);
        idle();
        tick();
        check_wb("flush_wb1", '0);
        tick();
        check_wb("flush_wb2", '0);

        // Three back-to-back external stalls behind an in-flight LDUR
        drive(OP_LDUR, 1'b1, 5'd1, 5'd2, 5'd11, 1'b0, 1'b0);
        tick();
        drive(OP_ADD, 1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 1'b0);
        tick();
        check_ex("stall1_ex", '0);
        check_mem("stall1_mem", {4'b1000, 5'd11});
        tick();
        check_ex("stall2_ex", '0);
        check_wb("stall2_wb", {2'b11, 5'd11});
        tick();
        check_ex("stall3_ex", '0);
        check_wb("stall3_wb", '0);
        drive(OP_ADD, 1'b1, 5'd1, 5'd2, 5'd12, 1'b0, 1'b0);
        tick();
        check_ex("post_stall_ex", {1'b0, 1'b0, 2'b10, 5'd12});
        idle();
        tick(); tick(); tick();

        // stall together with flush behaves as flush alone
        drive(OP_ADD, 1'b1, 5'd1, 5'd2, 5'd13, 1'b0, 1'b0);
        tick();
        drive(OP_SUB, 1'b1, 5'd1, 5'd2, 5'd14, 1'b0, 1'b0);
        tick();
        drive(OP_ADD, 1'b1, 5'd1, 5'd2, 5'd15, 1'b1, 1'b1);
        tick();
        check_ex("sf_ex", '0);
        check_mem("sf_mem", '0);
        check_wb("sf_wb", {2'b10, 5'd13});
        idle();
        tick();
        check_wb("sf_wb2", '0);
        tick(); tick();

        // Extended ops: CBNZ and ADDI only decode with EXT_OPS=1
        drive(OP_CBNZ, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        check_ex("cbnz_ex", {1'b1, 1'b0, 2'b01, 5'd0});
        check("cbnz0_ex_ctrl", {bus0.ex_reg2loc, bus0.ex_alusrc, bus0.ex_aluop}, 0);
        drive(OP_ADDI, 1'b1, 5'd0, 5'd0, 5'd20, 1'b0, 1'b0);
        tick();
        check_mem("cbnz_mem", {4'b0011, 5'd0});
        check("cbnz0_mem_ctrl", {bus0.mem_memread, bus0.mem_memwrite, bus0.mem_branch,
                                 bus0.mem_zinv}, 0);
        check_ex("addi_ex", {1'b0, 1'b1, 2'b10, 5'd20});
        check("addi0_ex_ctrl", {bus0.ex_reg2loc, bus0.ex_alusrc, bus0.ex_aluop}, 0);
        idle();
        tick();
        tick();
        check_wb("addi_wb", {2'b10, 5'd20});
        check("addi0_wb_regwrite", bus0.wb_regwrite, 0);

        // Unknown opcode with id_valid=1, then a real opcode with id_valid=0
        drive(OP_UNK, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        check_ex("unk_ex", '0);
        drive(OP_LDUR, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        check_mem("unk_mem", '0);
        check_ex("invalid_ex", '0);
        idle();
        tick();
        check_wb("unk_wb", '0);
        check_mem("invalid_mem", '0);
        tick();
        check_wb("invalid_wb", '0);

        // Load-use: LDUR rd=5 then ADD reading x5
        drive(OP_LDUR, 1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
        tick();
        drive(OP_ADD, 1'b1, 5'd5, 5'd1, 5'd21, 1'b0, 1'b0);
        #1;
`ifdef PIPE_CTRL_HAZARD_DETECT_EN
        check("hz_stall_req", bus1.stall_req, 1);
        tick();
        check_ex("hz_bubble_ex", '0);
        check("hz_stall_req_clear", bus1.stall_req, 0);
        tick();
        check_ex("hz_add_late_ex", {1'b0, 1'b0, 2'b10, 5'd21});
`else
        check("hz_stall_req_off", bus1.stall_req, 0);
        tick();
        check_ex("hz_add_ex", {1'b0, 1'b0, 2'b10, 5'd21});
`endif
        idle();
        tick();

        // A load to XZR is never a dependency
        drive(OP_LDUR, 1'b1, 5'd0, 5'd0, 5'd31, 1'b0, 1'b0);
        tick();
        drive(OP_ADD, 1'b1, 5'd31, 5'd31, 5'd22, 1'b0, 1'b0);
        #1;
        check("xzr_stall_req", bus1.stall_req, 0);
        tick();
        check_ex("xzr_add_ex", {1'b0, 1'b0, 2'b10, 5'd22});
        idle();
        tick(); tick(); tick();

        // Mid-pipeline reset clears every stage before the next edge
        drive(OP_LDUR, 1'b1, 5'd0, 5'd0, 5'd15, 1'b0, 1'b0);
        tick();
        drive(OP_ADD, 1'b1, 5'd0, 5'd0, 5'd16, 1'b0, 1'b0);
        tick();
        drive(OP_SUB, 1'b1, 5'd0, 5'd0, 5'd17, 1'b0, 1'b0);
        tick();
        check_wb("pre_rst_wb", {2'b11, 5'd15});
        idle();
        #2;
        reset = 1'b0;
        #1;
        check_ex("async_rst_ex", '0);
        check_mem("async_rst_mem", '0);
        check_wb("async_rst_wb", '0);
        check("async_rst_stall_req", bus1.stall_req, 0);
        @(negedge clk);
        reset = 1'b1;
        drive(OP_ADD, 1'b1, 5'd0, 5'd0, 5'd18, 1'b0, 1'b0);
        tick();
        check_ex("post_rst_ex", {1'b0, 1'b0, 2'b10, 5'd18});
        check_mem("post_rst_mem", '0);
        check_wb("post_rst_wb", '0);
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
